change_logger: RTL
==================

// Module: change_logger
// PURPOSE
//  Consumes the 32-bit `value`/`debug` outputs of the delay stage. Detects every change of
//  `value` and logs it with a free-running timestamp into a small show-ahead FIFO.
//  Log entries drain over a valid/ready port to the monitor/UART side.
//  Replaces $monitor-style observation with a synthesizable event log.
// PARAMETERS
//  DEPTH  8   FIFO entries; power of two, >= 2
//  TS_W   16  timestamp width in bits; the counter wraps modulo 2**TS_W
// PORTS
//  clk        in   1         single clock, rising edge
//  reset      in   1         asynchronous, active-high; all state clears immediately
//  value      in   32        monitored word from the delay stage
//  debug      in   32        debug word from the delay stage
//  out_valid  out  1         FIFO head holds a valid entry
//  out_ready  in   1         consumer accepts the head this cycle
//  out_value  out  32        logged value
//  out_stamp  out  TS_W      timestamp of the change
//  out_debug  out  32        logged debug word (only with CHANGE_DEBUG_EN)
//  level      out  clog2(DEPTH)+1  number of occupied entries
//  overflow   out  1         sticky: an event was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset values: out_valid=0, out_value=0, out_stamp=0, out_debug=0, level=0,
//    overflow=0, stamp counter=0, prev=0, state=BASELINE.
//  - Stamp counter: increments on every clk edge after reset deasserts; wraps FFFF->0000.
//  - FSM BASELINE: on the first edge after reset, latch prev<=value, log nothing, go to RUN.
//  - FSM RUN: on each edge, if value!=prev then an event exists, and prev<=value.
//    The event carries {value, current stamp}.
//  - Event latency: a change sampled at edge N is visible at the head at edge N+1,
//    when the FIFO was empty.
//  - Consecutive changes are each logged; there is no coalescing.
//  - Handshake: pop occurs when out_valid && out_ready.
//    out_* are stable while out_valid=1 and no pop occurs.
//    out_* are don't-care when out_valid=0.
//  - Full: a push is accepted if level<DEPTH, or if a pop happens in the same cycle.
//    Otherwise the event is dropped, overflow<=1, and prev still updates.
//  - Empty plus simultaneous push: the entry appears the next cycle; no bypass path.
//  - Pointers are clog2(DEPTH) bits and wrap naturally.
//    level updates +1 on push only, -1 on pop only, unchanged on both or neither.
//  - overflow clears only on reset.
//  - Reset mid-operation: the FIFO is emptied, pending entries are lost, the FSM
//    returns to BASELINE, and the stamp restarts at 0.
// CONFIGURATION
//  CHANGE_DEBUG_EN defined: each entry also stores `debug` as sampled at the event edge.
//    out_debug presents it.
//  CHANGE_DEBUG_EN undefined: `debug` is ignored and out_debug is tied to 0.
//    Entry storage shrinks by 32 bits.
// STRUCTURE
//  - Package change_logger_pkg: typedef log_entry_t {value[31:0], stamp, [debug]};
//    state enum {BASELINE, RUN}; default DEPTH and TS_W constants.
//  - Sub-module cl_fifo: synchronous show-ahead FIFO of log_entry_t.
//    Ports: push, pop, din, dout, level, full, empty. Same clk/reset.
//  - Top level holds the FSM, prev register, stamp counter and overflow flag.
// TESTING
//  1. Reset for 2 cycles, value held at 0x00000005 -> no entries, out_valid=0,
//     overflow=0, level=0.
//  2. Change value to 0x0000000A at stamp 7, out_ready=1 -> one entry
//     {0x0000000A, 7} next cycle, then out_valid=0.
//  3. out_ready=0, value changes on 10 consecutive cycles with DEPTH=8 -> level=8,
//     overflow=1, and the 8 oldest entries drain in order with increasing stamps.
//  4. FIFO full, new change and out_ready=1 in the same cycle -> push accepted,
//     level stays 8, overflow unchanged.
//  5. 4 entries queued, assert reset mid-stream -> out_valid=0 and level=0 immediately;
//     the first post-reset change is logged with a small stamp (counter restarted).
//  6. Build with CHANGE_DEBUG_EN, debug=0xDEADBEEF at the change edge ->
//     out_debug=0xDEADBEEF. Build without it -> out_debug=0.

Source files
------------

// File: rtl/change_logger_pkg.sv
// change_logger_pkg: shared state enum, default sizes and log entry layout.
// CHANGE_DEBUG_EN adds a 32-bit debug field to each entry.
package change_logger_pkg;
  localparam int DEPTH_DEF = 8;
  localparam int TS_W_DEF  = 16;
  typedef enum logic {BASELINE, RUN} state_e;
  typedef struct packed {
    logic [31:0]         value;
    logic [TS_W_DEF-1:0] stamp;
`ifdef CHANGE_DEBUG_EN
    logic [31:0]         debug;
`endif
  } log_entry_t;
endpackage

// File: rtl/change_logger_fifo.sv
// cl_fifo: synchronous show-ahead FIFO; dout presents the head and reads as zero when empty.
module cl_fifo
  import change_logger_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter type T     = log_entry_t,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  T            din,
  output T            dout,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty
);
  T mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] level_q;
  logic do_pop, do_push;
  assign empty   = level_q == '0;
  assign full    = level_q == (AW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = level_q;
  assign dout    = empty ? '0 : mem_q[rd_q];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
    end else begin
      rd_q    <= rd_q + AW'(do_pop);
      wr_q    <= wr_q + AW'(do_push);
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/change_logger.sv
// change_logger: logs every change of value with a wrapping timestamp into a show-ahead FIFO.
// CHANGE_DEBUG_EN: each entry also carries debug; otherwise out_debug is tied to 0.
module change_logger
  import change_logger_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TS_W  = TS_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            value,
  input  logic [31:0]            debug,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_value,
  output logic [TS_W-1:0]        out_stamp,
  output logic [31:0]            out_debug,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  typedef struct packed {
    logic [31:0]     value;
    logic [TS_W-1:0] stamp;
`ifdef CHANGE_DEBUG_EN
    logic [31:0]     debug;
`endif
  } entry_t;
  state_e state_q;
  logic [31:0] prev_q;
  logic [TS_W-1:0] stamp_q;
  logic overflow_q, overflow_d, change, pop, push, full, empty;
  entry_t din, dout;
  assign change     = state_q == RUN && value != prev_q;
  assign pop        = out_valid && out_ready;
  assign push       = change && (!full || pop);
  assign overflow_d = overflow_q || (change && !push);
  // prev tracks value every cycle, so a dropped event still updates the baseline
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= BASELINE;
      prev_q     <= '0;
      stamp_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= RUN;
      prev_q     <= value;
      stamp_q    <= stamp_q + 1'b1;
      overflow_q <= overflow_d;
    end
  cl_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .level (level),
    .full  (full),
    .empty (empty)
  );
  assign out_valid = !empty;
  assign out_value = dout.value;
  assign out_stamp = dout.stamp;
  assign overflow  = overflow_q;
`ifdef CHANGE_DEBUG_EN
  assign din       = {value, stamp_q, debug};
  assign out_debug = dout.debug;
`else
  logic unused_debug;
  assign unused_debug = ^debug;
  assign din          = {value, stamp_q};
  assign out_debug    = '0;
`endif
endmodule
